// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that shares one external bit-serial adder among N_REQ
// requesters, streaming operands LSB-first and reassembling the parallel sum.
module serial_add_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   add_vld,
  output logic                   add_a,
  output logic                   add_b,
  output logic                   add_last,
  input  logic                   add_sum,
  output logic                   res_vld,
  output logic [WIDTH-1:0]       res_sum,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_rdy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;

  logic             w_any;
  logic [IDW-1:0]   w_gnt;
  logic             w_last_bit;

  // First valid requester at or after ptr, wrapping; the lowest offset wins.
  function automatic logic [IDW-1:0] pick_grant(input logic [N_REQ-1:0] vld,
                                                input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] idx;
    pick_grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (vld[idx]) pick_grant = idx;
    end
  endfunction

  assign w_any      = |req_vld;
  assign w_gnt      = pick_grant(req_vld, r_ptr);
  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // Grant is combinational on req_vld but forced low while reset is held.
  assign req_rdy  = (r_state == S_IDLE && w_any && !rst) ? (N_REQ'(1) << w_gnt) : '0;
  assign add_vld  = (r_state == S_RUN);
  assign add_a    = add_vld & r_a[0];
  assign add_b    = add_vld & r_b[0];
  assign add_last = add_vld & w_last_bit;
  assign res_vld  = (r_state == S_DONE);
  assign res_sum  = r_res;
  assign res_id   = r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= req_a[w_gnt*WIDTH +: WIDTH];
            r_b     <= req_b[w_gnt*WIDTH +: WIDTH];
            r_id    <= w_gnt;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {add_sum, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last_bit) r_state <= S_DONE;
        end
        S_DONE: begin
          if (res_rdy) begin
            r_ptr   <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + IDW'(1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench for serial_add_scheduler: directed scenarios plus random
// traffic, checked against an arithmetic/round-robin model and an adder model.
module tb_serial_add_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_vld;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_rdy;
  logic             add_vld, add_a, add_b, add_last, add_sum;
  logic             res_vld;
  logic [W-1:0]     res_sum;
  logic [IW-1:0]    res_id;
  logic             res_rdy;

  always #5 clk = ~clk;

  serial_add_scheduler #(.N_REQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_rdy  (req_rdy),
    .add_vld  (add_vld),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_last (add_last),
    .add_sum  (add_sum),
    .res_vld  (res_vld),
    .res_sum  (res_sum),
    .res_id   (res_id),
    .res_rdy  (res_rdy)
  );

  // External serial adder: carry cleared on reset and after the last bit.
  logic carry;
  always @(posedge clk or posedge rst) begin
    if (rst) carry <= 1'b0;
    else if (add_vld) carry <= add_last ? 1'b0 : ((add_a & add_b) | (add_a & carry) | (add_b & carry));
  end
  assign add_sum = add_a ^ add_b ^ carry;

  int n_total = 0;
  int n_bad   = 0;

  logic [N-1:0] pend;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int           m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    req_vld = pend;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic add_random();
    for (int i = 0; i < N; i++)
      if (!pend[i] && $urandom_range(0, 2) == 0) post(i, W'($urandom), W'($urandom));
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Entered just after a negedge with requests driven and the DUT idle.
  task automatic serve(input int hold, input bit rnd, output int g);
    logic [W-1:0] ea, eb, es;
    g = model_grant();
    check("grant_exists", 32'(g >= 0), 32'd1);
    if (g < 0) return;
    ea = opa[g];
    eb = opb[g];
    es = ea + eb;
    check("req_rdy", 32'(req_rdy), 32'd1 << g);
    check("idle_add_vld", 32'(add_vld), 32'd0);
    check("idle_res_vld", 32'(res_vld), 32'd0);
    @(posedge clk);
    pend[g] = 1'b0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (rnd) add_random();
      drive_reqs();
      #1;
      check("add_vld", 32'(add_vld), 32'd1);
      check("add_a", 32'(add_a), 32'(ea[k]));
      check("add_b", 32'(add_b), 32'(eb[k]));
      check("add_last", 32'(add_last), 32'(k == W - 1));
      check("run_req_rdy", 32'(req_rdy), 32'd0);
      check("run_res_vld", 32'(res_vld), 32'd0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      res_rdy = (h == hold);
      #1;
      check("res_vld", 32'(res_vld), 32'd1);
      check("res_sum", 32'(res_sum), 32'(es));
      check("res_id", 32'(res_id), 32'(g));
      check("done_add_vld", 32'(add_vld), 32'd0);
      check("done_req_rdy", 32'(req_rdy), 32'd0);
    end
    @(posedge clk);
    m_ptr = (g + 1) % N;
  endtask

  task automatic next_op(input int hold, input bit rnd, output int g);
    @(negedge clk);
    drive_reqs();
    #1;
    serve(hold, rnd, g);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_onehot0", 32'($onehot0(req_rdy)), 32'd1);
      check("last_implies_vld", 32'(add_last & ~add_vld), 32'd0);
      check("vld_not_in_done", 32'(add_vld & res_vld), 32'd0);
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    pend    = '0;
    m_ptr   = 0;
    res_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    drive_reqs();

    // Reset values, with a request present to show req_rdy stays low.
    @(negedge clk);
    post(2, 8'h11, 8'h22);
    drive_reqs();
    #1;
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_add_vld", 32'(add_vld), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_last", 32'(add_last), 32'd0);
    check("rst_res_vld", 32'(res_vld), 32'd0);
    check("rst_res_sum", 32'(res_sum), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    pend = '0;
    drive_reqs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_empty_rdy", 32'(req_rdy), 32'd0);

    // Single request.
    post(0, 8'h3C, 8'h05);
    next_op(0, 1'b0, g);
    // Overflow then zero sum: no stale carry.
    post(2, 8'hFF, 8'h01);
    next_op(0, 1'b0, g);
    post(1, 8'h00, 8'h00);
    next_op(0, 1'b0, g);
    check("single_ignores_ptr", 32'(g), 32'd1);
    post(3, 8'h12, 8'h34);
    next_op(0, 1'b0, g);

    // Round-robin with all four requesting.
    for (int i = 0; i < N; i++) post(i, W'(8'h11 * i + 1), W'(8'h23 * i + 7));
    for (int j = 0; j < N; j++) begin
      next_op(0, 1'b0, g);
      check("rr_order", 32'(g), 32'(j));
    end
    for (int i = 0; i < N; i++) post(i, W'(8'h31 * i + 9), W'(8'h47 * i + 2));
    next_op(0, 1'b0, g);
    check("rr_wrap", 32'(g), 32'd0);
    while (pend != '0) next_op(0, 1'b0, g);

    // Back-pressure, then an accept one cycle after the handshake.
    post(2, 8'h5A, 8'h66);
    post(3, 8'h01, 8'h02);
    next_op(5, 1'b0, g);
    next_op(0, 1'b0, g);
    check("bp_next", 32'(g), 32'd3);

    // Reset after three bits of AA+55.
    @(negedge clk);
    post(0, 8'hAA, 8'h55);
    drive_reqs();
    #1;
    check("rstop_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk);
    pend[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_reqs();
      #1;
      check("rstop_bit_a", 32'(add_a), 32'(k % 2 == 1));
      check("rstop_bit_b", 32'(add_b), 32'(k % 2 == 0));
    end
    @(negedge clk);
    rst = 1'b1;
    post(1, 8'h80, 8'h80);
    drive_reqs();
    #1;
    check("rstop_add_vld", 32'(add_vld), 32'd0);
    check("rstop_res_vld", 32'(res_vld), 32'd0);
    check("rstop_req_rdy", 32'(req_rdy), 32'd0);
    m_ptr = 0;
    @(negedge clk);
    #1;
    check("rstop_res_vld2", 32'(res_vld), 32'd0);
    rst = 1'b0;
    #1;
    serve(0, 1'b0, g);
    post(2, 8'h7F, 8'h01);
    next_op(0, 1'b0, g);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pend == '0) post($urandom_range(0, N - 1), W'($urandom), W'($urandom));
      add_random();
      drive_reqs();
      #1;
      serve($urandom_range(0, 3), 1'b1, g);
    end
    while (pend != '0) next_op(0, 1'b0, g);

    @(negedge clk);
    drive_reqs();
    #1;
    check("final_idle_rdy", 32'(req_rdy), 32'd0);
    check("final_idle_vld", 32'(add_vld | res_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add_scheduler.md
# serial_add_scheduler

Shares one bit-serial adder among `N_REQ` requesters that each hold a parallel operand pair. Round-robin arbitration picks a requester. The operands are streamed LSB-first into the adder using the adder's valid/last protocol. The serial sum bits are collected into a parallel result, which is returned with the winning requester's ID. The block sits between parallel client logic and the serial adder datapath; the adder itself is external.

## Interface

Parameters:
- `N_REQ`, default 4 — number of requesters; must be ≥ 2.
- `WIDTH`, default 8 — operand and result width in bits; must be ≥ 2.
- `IDW`, default `$clog2(N_REQ)` — width of the requester ID.

Ports:
- `clk` — in, 1 — single clock; all logic is on the rising edge.
- `rst` — in, 1 — asynchronous, active-high reset.
- `req_vld` — in, N_REQ — per-requester operand valid.
- `req_a` — in, N_REQ*WIDTH — operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` — in, N_REQ*WIDTH — operand B, same packing as `req_a`.
- `req_rdy` — out, N_REQ — per-requester accept; one-hot or zero.
- `add_vld` — out, 1 — serial adder bit valid.
- `add_a` — out, 1 — serial operand bit A.
- `add_b` — out, 1 — serial operand bit B.
- `add_last` — out, 1 — marks the MSB bit of the current operation.
- `add_sum` — in, 1 — adder sum bit, combinational from the same-cycle `add_a`/`add_b` and the adder's stored carry.
- `res_vld` — out, 1 — result valid.
- `res_sum` — out, WIDTH — result, (A+B) mod 2^WIDTH.
- `res_id` — out, IDW — index of the requester that owns the result.
- `res_rdy` — in, 1 — result consumer ready.

## Operation

- The FSM has three states: IDLE, RUN and DONE. Reset puts it in IDLE.
- **IDLE**
  - `req_rdy[g]` = 1 for the grant `g`: the first i with `req_vld[i]` = 1, searching from pointer `ptr` upward and wrapping.
  - `req_rdy` depends combinationally on `req_vld`.
  - If any `req_vld` is set: latch `req_a[g]` and `req_b[g]` into shift registers, latch `g` into the ID register, clear the bit counter, and go to RUN.
  - If no `req_vld` is set, stay in IDLE.
- **RUN**
  - `add_vld` = 1. `add_a`/`add_b` = bit 0 of the respective shift register.
  - `add_last` = 1 when the bit counter equals WIDTH-1.
  - Each cycle:
    - shift both operand registers right;
    - capture `add_sum` into the result register as `res <= {add_sum, res[WIDTH-1:1]}`;
    - increment the counter.
  - After the `add_last` cycle, go to DONE.
- **DONE**
  - `res_vld` = 1; `res_sum` and `res_id` are held stable.
  - When `res_vld & res_rdy`: go to IDLE and set `ptr <= (res_id + 1) mod N_REQ`.
- Outputs outside RUN: `add_vld`, `add_a`, `add_b` and `add_last` are all 0.
- Outside IDLE, `req_rdy` is all 0.
- The final carry-out is discarded. The adder clears its carry on `vld & last`, so consecutive operations are independent.
- Requesters keep `req_vld` and their operands stable until they are accepted. A non-granted requester keeps waiting.
- Reset values: `req_rdy` = 0, `add_*` = 0, `res_vld` = 0, `res_sum` = 0, `res_id` = 0, `ptr` = 0, state = IDLE.

## Timing

- An accept happens in cycle T, which is an IDLE cycle with `req_vld[g] & req_rdy[g]`.
- Bit k (LSB = 0) is driven in cycle T+1+k. `add_last` is asserted in cycle T+WIDTH.
- `res_vld` rises in cycle T+WIDTH+1.
- With `res_rdy` held high, `res_vld` lasts 1 cycle. The next accept is possible at T+WIDTH+2, giving a minimum period of WIDTH+2 cycles.
- `add_last` is asserted exactly once per operation. `add_vld` is continuous for WIDTH cycles, with no gaps.
- Back-pressure: while `res_rdy` = 0 in DONE, the block holds the result and accepts nothing.
- Simultaneous requests: the grant is decided by `ptr` alone. A single active requester is granted regardless of `ptr`.
- `rst` asserted mid-RUN or mid-DONE:
  - all outputs go to their reset values immediately (asynchronously);
  - the in-flight operation is dropped, with no `res_vld`;
  - the adder shares `rst`, so its carry is cleared too.
- `rst` released: the first accept is possible on the first rising edge with `rst` low.

## Test plan

- **Single request:** requester 0, A = 8'h3C, B = 8'h05 → `req_rdy[0]` high in cycle T; `add_last` in T+8; `res_vld` in T+9 with `res_sum` = 8'h41, `res_id` = 0.
- **Overflow and carry isolation:** 8'hFF + 8'h01 → `res_sum` = 8'h00. An immediately following 8'h00 + 8'h00 → 8'h00, showing no stale carry.
- **Round-robin:** all 4 `req_vld` held high with distinct operands → grant order 0, 1, 2, 3, 0, and every `res_sum`/`res_id` pair is correct.
- **Back-pressure:** `res_rdy` low for 5 cycles after `res_vld` → `res_sum`/`res_id` stable, `req_rdy` = 0 and `add_vld` = 0 throughout; the next accept comes 1 cycle after the handshake.
- **Reset mid-operation:** assert `rst` after 3 bits of 8'hAA + 8'h55 → `add_vld` drops in the same cycle and no `res_vld` appears. After release, 8'h80 + 8'h80 → 8'h00, and 8'h7F + 8'h01 → 8'h80.
- **Protocol checks (assertions):** in every run, `add_last` implies `add_vld`; exactly one `add_last` per accept; `req_rdy` is one-hot or zero; `add_vld` is never high in IDLE or DONE.
